// File: rtl/exu_oitf.sv
// Outstanding Instruction Track FIFO: in-order tracker of long-pipe destinations.
// Feeds RAW/WAW hazard flags to dispatch and retires in allocation order.
module exu_oitf #(
   parameter int unsigned OITF_DEPTH  = 4,
   parameter int unsigned PTR_W       = $clog2(OITF_DEPTH),
   parameter int unsigned RFIDX_WIDTH = 5,
   parameter int unsigned PC_SIZE     = 32
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   flush,
   input  logic                   dis_ena,
   output logic                   dis_ready,
   input  logic                   dis_rdwen,
   input  logic [RFIDX_WIDTH-1:0] dis_rdidx,
   input  logic [PC_SIZE-1:0]     dis_pc,
   output logic [PTR_W-1:0]       dis_ptr,
   input  logic                   ret_ena,
   output logic [PTR_W-1:0]       ret_ptr,
   output logic                   ret_rdwen,
   output logic [RFIDX_WIDTH-1:0] ret_rdidx,
   output logic [PC_SIZE-1:0]     ret_pc,
   output logic                   oitf_empty,
   input  logic                   disp_i_rs1en,
   input  logic                   disp_i_rs2en,
   input  logic                   disp_i_rdwen,
   input  logic [RFIDX_WIDTH-1:0] disp_i_rs1idx,
   input  logic [RFIDX_WIDTH-1:0] disp_i_rs2idx,
   input  logic [RFIDX_WIDTH-1:0] disp_i_rdidx,
   output logic                   oitfrd_match_disprs1,
   output logic                   oitfrd_match_disprs2,
   output logic                   oitfrd_match_disprd
);

   localparam logic [PTR_W-1:0] LastIdx = PTR_W'(OITF_DEPTH - 1);

   logic [PTR_W-1:0]       alc_ptr_q, alc_ptr_d, ret_ptr_q, ret_ptr_d;
   logic                   alc_wrap_q, alc_wrap_d, ret_wrap_q, ret_wrap_d;
   logic [OITF_DEPTH-1:0]  vld_q, vld_d;
   logic [OITF_DEPTH-1:0]  rdwen_q;
   logic [RFIDX_WIDTH-1:0] rdidx_q [OITF_DEPTH];
   logic [PC_SIZE-1:0]     pc_q    [OITF_DEPTH];

   logic full, empty, alc_fire, ret_fire;

   // Occupancy from pointer/wrap-bit comparison; depends on registered state only
   always_comb begin
      empty    = (alc_ptr_q == ret_ptr_q) && (alc_wrap_q == ret_wrap_q);
      full     = (alc_ptr_q == ret_ptr_q) && (alc_wrap_q != ret_wrap_q);
      alc_fire = dis_ena && !full;
      ret_fire = ret_ena && !empty;
   end

   // Next-state for pointers and valid bits; flush overrides both handshakes
   always_comb begin
      alc_ptr_d  = alc_ptr_q;
      alc_wrap_d = alc_wrap_q;
      ret_ptr_d  = ret_ptr_q;
      ret_wrap_d = ret_wrap_q;
      vld_d      = vld_q;
      if (flush) begin
         alc_ptr_d  = '0;
         alc_wrap_d = 1'b0;
         ret_ptr_d  = '0;
         ret_wrap_d = 1'b0;
         vld_d      = '0;
      end else begin
         // Allocate and retire never hit the same slot: that needs full or empty
         if (ret_fire) begin
            vld_d[ret_ptr_q] = 1'b0;
            if (ret_ptr_q == LastIdx) begin
               ret_ptr_d  = '0;
               ret_wrap_d = ~ret_wrap_q;
            end else begin
               ret_ptr_d = ret_ptr_q + 1'b1;
            end
         end
         if (alc_fire) begin
            vld_d[alc_ptr_q] = 1'b1;
            if (alc_ptr_q == LastIdx) begin
               alc_ptr_d  = '0;
               alc_wrap_d = ~alc_wrap_q;
            end else begin
               alc_ptr_d = alc_ptr_q + 1'b1;
            end
         end
      end
   end

   // Pointer, wrap and valid state
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         alc_ptr_q  <= '0;
         alc_wrap_q <= 1'b0;
         ret_ptr_q  <= '0;
         ret_wrap_q <= 1'b0;
         vld_q      <= '0;
      end else begin
         alc_ptr_q  <= alc_ptr_d;
         alc_wrap_q <= alc_wrap_d;
         ret_ptr_q  <= ret_ptr_d;
         ret_wrap_q <= ret_wrap_d;
         vld_q      <= vld_d;
      end
   end

   // Entry payload; flush leaves it untouched since valid bits gate its use
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rdwen_q <= '0;
         for (int i = 0; i < OITF_DEPTH; i++) begin
            rdidx_q[i] <= '0;
            pc_q[i]    <= '0;
         end
      end else if (alc_fire && !flush) begin
         rdwen_q[alc_ptr_q] <= dis_rdwen;
         rdidx_q[alc_ptr_q] <= dis_rdidx;
         pc_q[alc_ptr_q]    <= dis_pc;
      end
   end

   // Hazard search across all valid, rd-writing entries
   always_comb begin
      logic hit1, hit2, hitd;
      hit1 = 1'b0;
      hit2 = 1'b0;
      hitd = 1'b0;
      for (int i = 0; i < OITF_DEPTH; i++) begin
         if (vld_q[i] && rdwen_q[i]) begin
            if (rdidx_q[i] == disp_i_rs1idx) hit1 = 1'b1;
            if (rdidx_q[i] == disp_i_rs2idx) hit2 = 1'b1;
            if (rdidx_q[i] == disp_i_rdidx)  hitd = 1'b1;
         end
      end
      // x0 is never a real dependency
      oitfrd_match_disprs1 = hit1 && disp_i_rs1en && (disp_i_rs1idx != '0);
      oitfrd_match_disprs2 = hit2 && disp_i_rs2en && (disp_i_rs2idx != '0);
      oitfrd_match_disprd  = hitd && disp_i_rdwen && (disp_i_rdidx != '0);
   end

   // Head-of-queue view and status outputs
   always_comb begin
      dis_ready  = !full;
      dis_ptr    = alc_ptr_q;
      ret_ptr    = ret_ptr_q;
      ret_rdwen  = rdwen_q[ret_ptr_q];
      ret_rdidx  = rdidx_q[ret_ptr_q];
      ret_pc     = pc_q[ret_ptr_q];
      oitf_empty = empty;
   end

endmodule

// File: tb/tb_exu_oitf.sv
// Self-checking bench for exu_oitf: directed vector table plus reset/async-reset sequences.
// Each vector drives inputs after a falling edge, checks pre-edge outputs, then clocks.
module tb_exu_oitf;

   logic        clk, rst, flush;
   logic        dis_ena, dis_ready, dis_rdwen;
   logic [4:0]  dis_rdidx;
   logic [31:0] dis_pc;
   logic [1:0]  dis_ptr, ret_ptr;
   logic        ret_ena, ret_rdwen;
   logic [4:0]  ret_rdidx;
   logic [31:0] ret_pc;
   logic        oitf_empty;
   logic        q1e, q2e, qde;
   logic [4:0]  q1, q2, qd;
   logic        m1, m2, md;

   int errors = 0;
   int checks = 0;

   exu_oitf #(
      .OITF_DEPTH (4),
      .PTR_W      (2),
      .RFIDX_WIDTH(5),
      .PC_SIZE    (32)
   ) dut (
      .clk                 (clk),
      .rst                 (rst),
      .flush               (flush),
      .dis_ena             (dis_ena),
      .dis_ready           (dis_ready),
      .dis_rdwen           (dis_rdwen),
      .dis_rdidx           (dis_rdidx),
      .dis_pc              (dis_pc),
      .dis_ptr             (dis_ptr),
      .ret_ena             (ret_ena),
      .ret_ptr             (ret_ptr),
      .ret_rdwen           (ret_rdwen),
      .ret_rdidx           (ret_rdidx),
      .ret_pc              (ret_pc),
      .oitf_empty          (oitf_empty),
      .disp_i_rs1en        (q1e),
      .disp_i_rs2en        (q2e),
      .disp_i_rdwen        (qde),
      .disp_i_rs1idx       (q1),
      .disp_i_rs2idx       (q2),
      .disp_i_rdidx        (qd),
      .oitfrd_match_disprs1(m1),
      .oitfrd_match_disprs2(m2),
      .oitfrd_match_disprd (md)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        fl, de, dw;
      logic [4:0]  di;
      logic [31:0] dpc;
      logic        re;
      logic        q1e;
      logic [4:0]  q1;
      logic        q2e;
      logic [4:0]  q2;
      logic        qde;
      logic [4:0]  qd;
      logic        e_empty, e_ready;
      logic [1:0]  e_dptr, e_rptr;
      logic        e_rw;
      logic [4:0]  e_ri;
      logic [31:0] e_rpc;
      logic        e_m1, e_m2, e_md;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(
      input logic fl, de, dw, input logic [4:0] di, input logic [31:0] dpc, input logic re,
      input logic a1e, input logic [4:0] a1, input logic a2e, input logic [4:0] a2,
      input logic ade, input logic [4:0] ad,
      input logic emp, rdy, input logic [1:0] dp, rp, input logic rw, input logic [4:0] ri,
      input logic [31:0] rpc, input logic x1, x2, xd);
      vec_t v;
      v.fl = fl; v.de = de; v.dw = dw; v.di = di; v.dpc = dpc; v.re = re;
      v.q1e = a1e; v.q1 = a1; v.q2e = a2e; v.q2 = a2; v.qde = ade; v.qd = ad;
      v.e_empty = emp; v.e_ready = rdy; v.e_dptr = dp; v.e_rptr = rp;
      v.e_rw = rw; v.e_ri = ri; v.e_rpc = rpc; v.e_m1 = x1; v.e_m2 = x2; v.e_md = xd;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic drive(input vec_t v);
      flush = v.fl; dis_ena = v.de; dis_rdwen = v.dw; dis_rdidx = v.di; dis_pc = v.dpc;
      ret_ena = v.re; q1e = v.q1e; q1 = v.q1; q2e = v.q2e; q2 = v.q2; qde = v.qde; qd = v.qd;
   endtask

   task automatic check_vec(input int n, input vec_t v);
      string t;
      t = $sformatf("v%0d", n);
      chk({t, ".empty"}, 32'(oitf_empty), 32'(v.e_empty));
      chk({t, ".ready"}, 32'(dis_ready), 32'(v.e_ready));
      chk({t, ".dis_ptr"}, 32'(dis_ptr), 32'(v.e_dptr));
      chk({t, ".ret_ptr"}, 32'(ret_ptr), 32'(v.e_rptr));
      // Head fields are don't-care while empty
      if (!v.e_empty) begin
         chk({t, ".ret_rdwen"}, 32'(ret_rdwen), 32'(v.e_rw));
         chk({t, ".ret_rdidx"}, 32'(ret_rdidx), 32'(v.e_ri));
         chk({t, ".ret_pc"}, ret_pc, v.e_rpc);
      end
      chk({t, ".m_rs1"}, 32'(m1), 32'(v.e_m1));
      chk({t, ".m_rs2"}, 32'(m2), 32'(v.e_m2));
      chk({t, ".m_rd"}, 32'(md), 32'(v.e_md));
   endtask

   task automatic idle_inputs();
      flush = 0; dis_ena = 0; dis_rdwen = 0; dis_rdidx = 0; dis_pc = 0; ret_ena = 0;
      q1e = 0; q1 = 0; q2e = 0; q2 = 0; qde = 0; qd = 0;
   endtask

   initial begin
      // fl de dw di dpc re | q1e q1 q2e q2 qde qd | emp rdy dptr rptr rw ri rpc | m1 m2 md
      // Basic allocate / hit / retire
      vecs.push_back(mk(0,0,0,0,0,0, 1,5,1,6,1,7, 1,1,0,0,0,0,0, 0,0,0));
      vecs.push_back(mk(0,1,1,5,32'h80000010,0, 1,5,0,0,0,0, 1,1,0,0,0,0,0, 0,0,0));
      vecs.push_back(mk(0,0,0,0,0,1, 1,5,1,6,1,5, 0,1,1,0,1,5,32'h80000010, 1,0,1));
      vecs.push_back(mk(0,0,0,0,0,0, 1,5,0,0,0,0, 1,1,1,1,0,0,0, 0,0,0));
      // Fill to full, overflow attempt, in-order drain with ret_ptr wrap 3->0
      vecs.push_back(mk(0,1,1,1,32'h100,0, 0,0,0,0,0,0, 1,1,1,1,0,0,0, 0,0,0));
      vecs.push_back(mk(0,1,1,2,32'h104,0, 1,1,0,0,0,0, 0,1,2,1,1,1,32'h100, 1,0,0));
      vecs.push_back(mk(0,1,1,3,32'h108,0, 0,0,1,2,0,0, 0,1,3,1,1,1,32'h100, 0,1,0));
      vecs.push_back(mk(0,1,1,4,32'h10c,0, 0,0,0,0,1,3, 0,1,0,1,1,1,32'h100, 0,0,1));
      vecs.push_back(mk(0,1,1,9,32'h999,0, 1,4,1,9,0,0, 0,0,1,1,1,1,32'h100, 1,0,0));
      vecs.push_back(mk(0,0,0,0,0,0, 1,9,0,0,0,0, 0,0,1,1,1,1,32'h100, 0,0,0));
      vecs.push_back(mk(0,0,0,0,0,1, 0,0,0,0,0,0, 0,0,1,1,1,1,32'h100, 0,0,0));
      vecs.push_back(mk(0,0,0,0,0,1, 0,0,0,0,0,0, 0,1,1,2,1,2,32'h104, 0,0,0));
      vecs.push_back(mk(0,0,0,0,0,1, 0,0,0,0,0,0, 0,1,1,3,1,3,32'h108, 0,0,0));
      vecs.push_back(mk(0,0,0,0,0,1, 1,4,0,0,0,0, 0,1,1,0,1,4,32'h10c, 1,0,0));
      vecs.push_back(mk(0,0,0,0,0,0, 1,4,0,0,0,0, 1,1,1,1,0,0,0, 0,0,0));
      // Refill, then simultaneous retire+dispatch when full and when not full
      vecs.push_back(mk(0,1,1,10,32'h200,0, 0,0,0,0,0,0, 1,1,1,1,0,0,0, 0,0,0));
      vecs.push_back(mk(0,1,1,11,32'h204,0, 0,0,0,0,0,0, 0,1,2,1,1,10,32'h200, 0,0,0));
      vecs.push_back(mk(0,1,1,12,32'h208,0, 0,0,0,0,0,0, 0,1,3,1,1,10,32'h200, 0,0,0));
      vecs.push_back(mk(0,1,1,13,32'h20c,0, 0,0,0,0,0,0, 0,1,0,1,1,10,32'h200, 0,0,0));
      vecs.push_back(mk(0,1,1,14,32'h210,1, 0,0,0,0,0,0, 0,0,1,1,1,10,32'h200, 0,0,0));
      vecs.push_back(mk(0,1,1,15,32'h214,1, 0,0,0,0,0,0, 0,1,1,2,1,11,32'h204, 0,0,0));
      vecs.push_back(mk(0,0,0,0,0,0, 1,15,1,14,1,10, 0,1,2,3,1,12,32'h208, 1,0,0));
      // Flush with concurrent dispatch: flush wins
      vecs.push_back(mk(1,1,1,20,32'h300,0, 1,12,0,0,0,0, 0,1,2,3,1,12,32'h208, 1,0,0));
      vecs.push_back(mk(0,0,0,0,0,0, 1,20,1,13,1,15, 1,1,0,0,0,0,0, 0,0,0));
      // x0 destination and store (rdwen=0) never match
      vecs.push_back(mk(0,1,1,0,32'h400,0, 0,0,0,0,0,0, 1,1,0,0,0,0,0, 0,0,0));
      vecs.push_back(mk(0,1,0,8,32'h404,0, 1,0,0,0,0,0, 0,1,1,0,1,0,32'h400, 0,0,0));
      vecs.push_back(mk(0,0,0,0,0,0, 1,8,1,0,1,8, 0,1,2,0,1,0,32'h400, 0,0,0));
      vecs.push_back(mk(0,0,0,0,0,1, 0,0,0,0,0,0, 0,1,2,0,1,0,32'h400, 0,0,0));
      vecs.push_back(mk(0,0,0,0,0,1, 1,8,0,0,0,0, 0,1,2,1,0,8,32'h404, 0,0,0));
      // Retire while empty is ignored
      vecs.push_back(mk(0,0,0,0,0,1, 0,0,0,0,0,0, 1,1,2,2,0,0,0, 0,0,0));
      vecs.push_back(mk(0,0,0,0,0,0, 0,0,0,0,0,0, 1,1,2,2,0,0,0, 0,0,0));

      idle_inputs();
      rst = 1'b1;
      #2;
      // Reset state, including head payload fields
      q1e = 1; q1 = 5; q2e = 1; q2 = 6; qde = 1; qd = 7;
      #1;
      chk("rst.empty", 32'(oitf_empty), 32'd1);
      chk("rst.ready", 32'(dis_ready), 32'd1);
      chk("rst.dis_ptr", 32'(dis_ptr), 32'd0);
      chk("rst.ret_ptr", 32'(ret_ptr), 32'd0);
      chk("rst.ret_rdwen", 32'(ret_rdwen), 32'd0);
      chk("rst.ret_rdidx", 32'(ret_rdidx), 32'd0);
      chk("rst.ret_pc", ret_pc, 32'd0);
      chk("rst.matches", {29'd0, m1, m2, md}, 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < vecs.size(); i++) begin
         @(negedge clk);
         drive(vecs[i]);
         #1;
         check_vec(i, vecs[i]);
      end

      // Three allocations, then an asynchronous reset pulse between clock edges
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         idle_inputs();
         dis_ena = 1; dis_rdwen = 1; dis_rdidx = 5'(21 + k); dis_pc = 32'h500 + 32'(4 * k);
      end
      @(negedge clk);
      idle_inputs();
      q1e = 1; q1 = 21;
      #1;
      chk("pre_arst.dis_ptr", 32'(dis_ptr), 32'd1);
      chk("pre_arst.m_rs1", 32'(m1), 32'd1);
      chk("pre_arst.ret_rdidx", 32'(ret_rdidx), 32'd21);
      rst = 1'b1;
      #1;
      rst = 1'b0;
      #1;
      chk("arst.empty", 32'(oitf_empty), 32'd1);
      chk("arst.ready", 32'(dis_ready), 32'd1);
      chk("arst.dis_ptr", 32'(dis_ptr), 32'd0);
      chk("arst.ret_ptr", 32'(ret_ptr), 32'd0);
      chk("arst.ret_rdidx", 32'(ret_rdidx), 32'd0);
      chk("arst.ret_pc", ret_pc, 32'd0);
      chk("arst.m_rs1", 32'(m1), 32'd0);

      @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/exu_oitf.md
Name: exu_oitf

Overview:
- Outstanding Instruction Track FIFO: an in-order scheduler for long-latency EXU operations (LSU loads, multi-cycle mul/div).
- It sits between exu_disp and the long-pipe write-back path.
- It records each dispatched long-pipe instruction's destination register.
- It gives dispatch combinational RAW/WAW hazard flags, so dispatch stalls while a source or destination is still pending.
- It retires entries strictly in allocation order as exu_wbck commits long-pipe results to the RegisterFile.

Parameters:
- OITF_DEPTH, 4, number of entries; power of two, at least 2.
- PTR_W, log2(OITF_DEPTH), entry index width.
- RFIDX_WIDTH, 5, register index width (matches `RFIDX_WIDTH).
- PC_SIZE, 32, PC width (matches `PC_SIZE).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- flush  in  1  synchronous clear of all entries.
- dis_ena  in  1  allocate one entry this cycle (dispatch handshake fired).
- dis_ready  out  1  an entry is free.
- dis_rdwen  in  1  allocated instruction writes rd.
- dis_rdidx  in  RFIDX_WIDTH  allocated instruction's rd.
- dis_pc  in  PC_SIZE  allocated instruction's PC.
- dis_ptr  out  PTR_W  index the next allocation will take; the long pipe tags its result with it.
- ret_ena  in  1  retire the oldest entry this cycle.
- ret_ptr  out  PTR_W  index of the oldest entry.
- ret_rdwen  out  1  oldest entry's rdwen.
- ret_rdidx  out  RFIDX_WIDTH  oldest entry's rd.
- ret_pc  out  PC_SIZE  oldest entry's PC.
- oitf_empty  out  1  no valid entries.
- disp_i_rs1en  in  1  query: rs1 read enable.
- disp_i_rs2en  in  1  query: rs2 read enable.
- disp_i_rdwen  in  1  query: rd write enable.
- disp_i_rs1idx  in  RFIDX_WIDTH  query: rs1 index.
- disp_i_rs2idx  in  RFIDX_WIDTH  query: rs2 index.
- disp_i_rdidx  in  RFIDX_WIDTH  query: rd index.
- oitfrd_match_disprs1  out  1  RAW hazard on rs1.
- oitfrd_match_disprs2  out  1  RAW hazard on rs2.
- oitfrd_match_disprd  out  1  WAW hazard on rd.

Behaviour:
- Reset (asynchronous, immediate on rst high):
  - alc_ptr, ret_ptr and both wrap bits = 0.
  - All entry valid bits = 0.
  - Entry rdwen, rdidx and pc fields = 0.
  - Resulting outputs: oitf_empty=1, dis_ready=1, dis_ptr=0, ret_ptr=0, ret_* = 0, all match flags = 0.
- Storage: circular buffer with PTR_W-bit alc/ret pointers plus one wrap bit each.
  - empty = pointers equal and wrap bits equal.
  - full = pointers equal and wrap bits differ.
- dis_ready = !full, registered-state only; no combinational path from ret_ena or dis_ena.
- Allocation, on a clock edge where dis_ena && dis_ready:
  - entry[alc_ptr] gets valid=1, rdwen, rdidx, pc.
  - alc_ptr increments; at OITF_DEPTH-1 it wraps to 0 and toggles its wrap bit.
  - dis_ena while full is ignored: no state change, no overwrite.
- Retirement, on a clock edge where ret_ena && !empty:
  - entry[ret_ptr].valid is cleared.
  - ret_ptr increments and wraps the same way.
  - ret_ena while empty is ignored.
- ret_ptr, ret_rdwen, ret_rdidx and ret_pc show the oldest entry combinationally.
  - When empty they show entry[ret_ptr] fields, which are don't-care.
- Simultaneous allocation and retirement in one cycle are both performed.
  - Occupancy is unchanged.
  - Legal when full (only the retire fires, since dis_ready=0) and when empty (only the allocate fires).
- Hazard flags are combinational, each an OR over all entries:
  - oitfrd_match_disprs1 = any valid entry with rdwen=1 and rdidx==disp_i_rs1idx, qualified by disp_i_rs1en and disp_i_rs1idx!=0.
  - oitfrd_match_disprs2: same rule with rs2.
  - oitfrd_match_disprd: same rule with rd, qualified by disp_i_rdwen and disp_i_rdidx!=0.
  - An entry allocated in the current cycle is not visible until the next cycle.
  - An entry retired in the current cycle still matches this cycle.
- Entries with rdwen=0 (e.g. stores) occupy a slot but never produce a match.
- Flush:
  - Synchronous; on the edge all valid bits, both pointers and both wrap bits clear to 0.
  - Flush has priority over dis_ena and ret_ena in the same cycle.
  - Entry data fields keep their values.
- Reset asserted mid-operation: all state returns to reset values immediately, regardless of clock.

Test Plan:
- Reset, then idle → oitf_empty=1, dis_ready=1, dis_ptr=0; all match flags 0 for rs1idx=5, rs2idx=6, rdidx=7 with all enables set.
- Allocate rd=5, pc=0x80000010; next cycle query rs1idx=5, rs1en=1 → oitfrd_match_disprs1=1, ret_rdidx=5, ret_pc=0x80000010; after ret_ena → match=0, oitf_empty=1.
- Allocate 4 entries with rd=1,2,3,4 → dis_ready=0 after the 4th; a 5th dis_ena with rd=9 is ignored; retire order gives ret_rdidx=1,2,3,4; ret_ptr wraps 3→0.
- When full, assert ret_ena and dis_ena together → only the retire takes effect (occupancy 3); next cycle assert both again with dis_ready=1 → occupancy stays 3, dis_ptr advances by 1.
- Allocate rd=0 with rdwen=1, plus a store with rdwen=0 and rd=8 → queries rs1idx=0 and rs1idx=8 both give match=0.
- With 3 entries valid, assert flush together with dis_ena → oitf_empty=1, dis_ptr=0, no entry allocated; asynchronous rst pulse mid-cycle → outputs return to reset values before the next clock edge.
